// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
package loader_pkg;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  typedef enum logic [3:0] {
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    SUM_HI,
    SUM_LO,
    VERIFY,
    CHECK,
    DONE,
    FAIL
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 16-bit
// words, writes them to RAM, reads the image back against a trailing
// checksum and releases the CPU only when both sums agree.
module prog_loader #(
  parameter int ADDR_W = loader_pkg::ADDR_W,
  parameter int DEPTH  = loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_q,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  import loader_pkg::*;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t          state, state_nxt;
  logic [7:0]      hi_byte;
  logic [ADDR_W:0] n_cnt;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] vcnt;
  logic [15:0]     checksum;
  logic [15:0]     stream_sum;
  logic [15:0]     read_sum;
  logic            vld_p1;

  logic            accept;
  logic [15:0]     rx_word;
  logic [ADDR_W:0] idx_inc;
  logic [ADDR_W:0] vcnt_inc;

  assign accept   = rx_valid && rx_ready;
  assign rx_word  = {hi_byte, rx_data};
  assign idx_inc  = idx + 1'b1;
  assign vcnt_inc = vcnt + 1'b1;

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= HDR_HI;
    else     state <= state_nxt;
  end

  // Next-state logic: byte-consuming states advance only on an accepted byte
  always_comb begin
    state_nxt = state;
    case (state)
      HDR_HI: if (accept) state_nxt = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (rx_word > DEPTH16)  state_nxt = FAIL;
          else if (rx_word == '0) state_nxt = SUM_HI;
          else                    state_nxt = DAT_HI;
        end
      end
      DAT_HI: if (accept) state_nxt = DAT_LO;
      DAT_LO: if (accept) state_nxt = WRITE;
      WRITE:  state_nxt = (idx_inc == n_cnt) ? SUM_HI : DAT_HI;
      SUM_HI: if (accept) state_nxt = SUM_LO;
      // An empty image still passes through one drain cycle of VERIFY
      SUM_LO: if (accept) state_nxt = VERIFY;
      VERIFY: if (vcnt == n_cnt) state_nxt = CHECK;
      CHECK:  state_nxt = (stream_sum == checksum && read_sum == checksum) ? DONE : FAIL;
      DONE:   state_nxt = DONE;
      FAIL:   state_nxt = FAIL;
      default: state_nxt = HDR_HI;
    endcase
  end

  // Outputs decoded purely from the current state
  always_comb begin
    rx_ready = 1'b0;
    mem_wren = 1'b0;
    done     = 1'b0;
    cpu_run  = 1'b0;
    error    = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO: rx_ready = 1'b1;
      WRITE: mem_wren = 1'b1;
      DONE: begin
        done    = 1'b1;
        cpu_run = 1'b1;
      end
      FAIL:  error = 1'b1;
      default: ;
    endcase
  end

  // Byte capture registers; contents are don't-care until the FSM consumes them
  always_ff @(posedge clk) begin
    if (accept && (state == HDR_HI || state == DAT_HI || state == SUM_HI))
      hi_byte <= rx_data;
    if (accept && state == HDR_LO)
      n_cnt <= rx_word[ADDR_W:0];
    if (accept && state == SUM_LO)
      checksum <= rx_word;
  end

  // Write/readback datapath: bus registers, index, verify counter and sums
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data    <= '0;
      mem_address <= '0;
      idx         <= '0;
      vcnt        <= '0;
      stream_sum  <= '0;
      read_sum    <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        DAT_LO: begin
          if (accept) begin
            mem_data    <= rx_word;
            mem_address <= idx[ADDR_W-1:0];
          end
        end
        WRITE: begin
          stream_sum <= sum16(stream_sum, mem_data);
          idx        <= idx_inc;
        end
        SUM_LO: begin
          if (accept) begin
            vcnt <= '0;
            if (n_cnt != '0) mem_address <= '0;
          end
        end
        // mem_q lags the address by one cycle; vld_p1 marks the returning word
        VERIFY: begin
          vcnt   <= vcnt_inc;
          vld_p1 <= (vcnt < n_cnt);
          if (vcnt_inc < n_cnt) mem_address <= vcnt_inc[ADDR_W-1:0];
          if (vld_p1) read_sum <= sum16(read_sum, mem_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: single-port RAM model, byte-stream driver and a
// stream-level reference model of the expected load outcome.
module tb_prog_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [15:0]   mem_data;
  logic          mem_wren;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_q;
  logic          cpu_run;
  logic          done;
  logic          error;

  logic          clr_req = 1'b0;
  logic          flip_req = 1'b0;

  int checks = 0;
  int failures = 0;
  int wr_total = 0;

  logic [15:0] ram [0:4095];
  logic [15:0] wq[$];
  logic [7:0]  sq[$];

  prog_loader #(.ADDR_W(AW), .DEPTH(4096)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_address(mem_address), .mem_q(mem_q), .cpu_run(cpu_run),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read; bench can clear it or flip a bit
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 16'h0000;
    end else begin
      if (flip_req) ram[3] <= ram[3] ^ 16'h0001;
      if (mem_wren) ram[mem_address] <= mem_data;
    end
    mem_q <= ram[mem_address];
  end

  // Write pulse monitor
  always @(posedge clk) if (mem_wren) wr_total <= wr_total + 1;

  function automatic logic [15:0] ref_sum();
    logic [15:0] s = 16'h0000;
    foreach (wq[i]) s = s + wq[i];
    return s;
  endfunction

  task automatic build_stream(input logic [15:0] n, input logic [15:0] cs);
    sq.delete();
    sq.push_back(n[15:8]);
    sq.push_back(n[7:0]);
    foreach (wq[i]) begin
      sq.push_back(wq[i][15:8]);
      sq.push_back(wq[i][7:0]);
    end
    sq.push_back(cs[15:8]);
    sq.push_back(cs[7:0]);
  endtask

  task automatic do_reset(input bit clr);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    clr_req = clr;
    @(negedge clk);
    rst = 1'b0;
    clr_req = 1'b0;
  endtask

  // Returns at the falling edge right after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int t = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      ok = 1'b0;
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic send_range(input int from, input int upto, input int maxgap, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int i = from; i < upto; i++) begin
      send_byte(sq[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, b_ok);
      if (!b_ok) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Cycles from the last accepted byte until done or error rises
  task automatic wait_outcome(input int bound, output int lat);
    lat = 0;
    while (!(done || error) && lat < bound) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic load_reference_words();
    wq = '{16'h8002, 16'h8100, 16'hC850, 16'hB802, 16'h8901, 16'hA0FC, 16'hC078};
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++; if (mem_wren !== 1'b0) begin failures++; $display("FAIL reset_mem_wren got=%b exp=0", mem_wren); end
    checks++; if (mem_data !== 16'h0) begin failures++; $display("FAIL reset_mem_data got=%h exp=0", mem_data); end
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    checks++; if ({cpu_run, done, error} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {cpu_run, done, error}); end
  endtask

  task automatic test_valid_load();
    bit ok; int lat; int w0; int bad;
    do_reset(1'b1);
    load_reference_words();
    build_stream(16'd7, 16'h6BC9);
    w0 = wr_total;
    send_range(0, sq.size(), 0, ok);
    wait_outcome(40, lat);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL valid_stream_accept got=%b exp=1", ok); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL valid_done_latency got=%0d exp=9", lat); end
    checks++; if ({done, cpu_run, error} !== 3'b110) begin failures++; $display("FAIL valid_status got=%b exp=110", {done, cpu_run, error}); end
    checks++; if (wr_total - w0 !== 7) begin failures++; $display("FAIL valid_write_pulses got=%0d exp=7", wr_total - w0); end
    bad = 0;
    foreach (wq[i]) if (ram[i] !== wq[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL valid_ram_image got=%0d bad words exp=0", bad); end
  endtask

  task automatic test_bad_checksum();
    bit ok; int lat; int w0; int rdy_hits;
    do_reset(1'b1);
    load_reference_words();
    build_stream(16'd7, 16'h6BC8);
    w0 = wr_total;
    send_range(0, sq.size(), 0, ok);
    wait_outcome(40, lat);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL badsum_stream_accept got=%b exp=1", ok); end
    checks++; if ({error, cpu_run, done} !== 3'b100) begin failures++; $display("FAIL badsum_status got=%b exp=100", {error, cpu_run, done}); end
    checks++; if (wr_total - w0 !== 7) begin failures++; $display("FAIL badsum_write_pulses got=%0d exp=7", wr_total - w0); end
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    rdy_hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (rx_ready !== 1'b0) rdy_hits++;
    end
    rx_valid = 1'b0;
    checks++; if (rdy_hits !== 0) begin failures++; $display("FAIL badsum_rx_ready_after got=%0d exp=0", rdy_hits); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL badsum_error_sticky got=%b exp=1", error); end
  endtask

  task automatic test_empty_and_oversize();
    bit ok; int lat; int w0;
    do_reset(1'b1);
    wq.delete();
    build_stream(16'd0, 16'h0000);
    w0 = wr_total;
    send_range(0, sq.size(), 0, ok);
    wait_outcome(20, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL empty_done_latency got=%0d exp=2", lat); end
    checks++; if ({done, cpu_run, error} !== 3'b110) begin failures++; $display("FAIL empty_status got=%b exp=110", {done, cpu_run, error}); end
    checks++; if (wr_total - w0 !== 0) begin failures++; $display("FAIL empty_write_pulses got=%0d exp=0", wr_total - w0); end

    do_reset(1'b1);
    sq = '{8'h10, 8'h01};
    w0 = wr_total;
    send_range(0, 2, 0, ok);
    checks++; if ({error, done, cpu_run} !== 3'b100) begin failures++; $display("FAIL oversize_status got=%b exp=100", {error, done, cpu_run}); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL oversize_rx_ready got=%b exp=0", rx_ready); end
    repeat (3) @(negedge clk);
    checks++; if (wr_total - w0 !== 0) begin failures++; $display("FAIL oversize_write_pulses got=%0d exp=0", wr_total - w0); end
  endtask

  task automatic test_ram_corruption();
    bit ok1, ok2; int lat;
    do_reset(1'b1);
    load_reference_words();
    build_stream(16'd7, 16'h6BC9);
    send_range(0, sq.size() - 1, 0, ok1);
    flip_req = 1'b1;
    @(negedge clk);
    flip_req = 1'b0;
    send_range(sq.size() - 1, sq.size(), 0, ok2);
    wait_outcome(40, lat);
    checks++; if (ram[3] !== (wq[3] ^ 16'h0001)) begin failures++; $display("FAIL corrupt_ram3 got=%h exp=%h", ram[3], wq[3] ^ 16'h0001); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL corrupt_error_latency got=%0d exp=9", lat); end
    checks++; if ({error, done, cpu_run} !== 3'b100) begin failures++; $display("FAIL corrupt_status got=%b exp=100 ok=%b%b", {error, done, cpu_run}, ok1, ok2); end
  endtask

  task automatic test_backpressure_random();
    bit ok; int lat; int bad; logic [15:0] cs; bit corrupt_sum; int n;
    do_reset(1'b1);
    load_reference_words();
    build_stream(16'd7, ref_sum());
    send_range(0, sq.size(), 5, ok);
    wait_outcome(40, lat);
    bad = 0;
    foreach (wq[i]) if (ram[i] !== wq[i]) bad++;
    checks++; if (bad !== 0 || ok !== 1'b1) begin failures++; $display("FAIL gaps_ram_image got=%0d bad words ok=%b exp=0", bad, ok); end
    checks++; if ({done, error} !== 2'b10) begin failures++; $display("FAIL gaps_status got=%b exp=10", {done, error}); end

    for (int it = 0; it < 8; it++) begin
      do_reset(1'b1);
      n = int'($urandom_range(1, 24));
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(16'($urandom));
      cs = ref_sum();
      corrupt_sum = ($urandom_range(0, 2) == 0);
      if (corrupt_sum) cs = cs + 16'($urandom_range(1, 65535));
      build_stream(16'(n), cs);
      send_range(0, sq.size(), 3, ok);
      wait_outcome(n + 20, lat);
      bad = 0;
      foreach (wq[i]) if (ram[i] !== wq[i]) bad++;
      checks++; if (bad !== 0 || ok !== 1'b1) begin failures++; $display("FAIL rand%0d_ram_image got=%0d bad words ok=%b exp=0", it, bad, ok); end
      checks++; if ({done, error} !== {!corrupt_sum, corrupt_sum}) begin failures++; $display("FAIL rand%0d_status got=%b exp=%b", it, {done, error}, {!corrupt_sum, corrupt_sum}); end
      checks++; if (lat !== n + 2) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, n + 2); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok; int lat;
    do_reset(1'b1);
    load_reference_words();
    build_stream(16'd7, 16'h6BC9);
    send_range(0, 10, 0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL midrst_rx_ready got=%b exp=1", rx_ready); end
    checks++; if ({mem_wren, mem_data, mem_address} !== '0) begin failures++; $display("FAIL midrst_bus got=%b/%h/%h exp=0", mem_wren, mem_data, mem_address); end
    checks++; if ({cpu_run, done, error} !== 3'b000) begin failures++; $display("FAIL midrst_status got=%b exp=000", {cpu_run, done, error}); end
    send_range(0, sq.size(), 2, ok);
    wait_outcome(40, lat);
    checks++; if ({done, cpu_run, error} !== 3'b110 || ok !== 1'b1) begin failures++; $display("FAIL midrst_replay got=%b ok=%b exp=110", {done, cpu_run, error}, ok); end
  endtask

  initial begin
    test_reset();
    test_valid_load();
    test_bad_checksum();
    test_empty_and_oversize();
    test_ram_corruption();
    test_backpressure_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
